uart_rx_fifo: RTL and testbench

//  Serial receive front end for the SoC: samples the asynchronous rx_i line (8N1),

---
 rtl/uart_rx_fifo.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with a small byte FIFO on a valid/ready stream
//
// Purpose:
//   Synchronizes the asynchronous rx_i line, finds start bits, samples each bit
//   mid-cell, reassembles bytes LSB first and queues good bytes in a circular
//   FIFO. Bad stop bits and bytes that arrive while the FIFO is full are reported
//   as one-cycle pulses.
// Ports:
//   clk          in   1  system clock, rising edge
//   reset_i      in   1  synchronous, active-high reset
//   rx_i         in   1  asynchronous serial input, idle high
//   data_o       out  8  FIFO head byte (registered), meaningful while valid_o=1
//   valid_o      out  1  FIFO non-empty
//   ready_i      in   1  consumer takes the head byte when valid_o & ready_i
//   frame_err_o  out  1  one-cycle pulse: stop bit sampled low, byte dropped
//   overrun_o    out  1  one-cycle pulse: good byte arrived with FIFO full, byte dropped

module uart_rx_fifo #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD_RATE   = 115200,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       reset_i,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frame_err_o,
   output logic       overrun_o
);

   localparam int CPB   = CLK_FREQ_HZ / BAUD_RATE;
   localparam int CNT_W = $clog2(CPB);
   localparam int AW    = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   // ---------------------------------------------------------------- sync
   logic r_rx_meta;
   logic r_rx_s;
   logic r_rx_prev;
   logic w_fall;

   always_ff @(posedge clk) begin
      if (reset_i) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= rx_i;
         r_rx_s    <= r_rx_meta;
         r_rx_prev <= r_rx_s;
      end
   end

   // A start is a 1->0 step of rx_s. After a bad stop bit the line is still
   // low, so r_rx_prev stays 0 and no new start is seen until rx_s returns high.
   assign w_fall = r_rx_prev & ~r_rx_s;

   // ---------------------------------------------------------------- FSM
   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_bit_idx;
   logic [7:0]        r_shift;
   logic              w_start_smp;
   logic              w_data_smp;
   logic              w_stop_smp;
   logic              w_push_req;
   logic              w_frame_err;

   always_ff @(posedge clk) begin
      if (reset_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_fall) w_state_nxt = S_START;
         S_START: if (w_start_smp) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
         S_DATA:  if (w_data_smp && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
         S_STOP:  if (w_stop_smp) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_start_smp = (r_state == S_START) && (r_cnt == CNT_HALF);
      w_data_smp  = (r_state == S_DATA)  && (r_cnt == CNT_LAST);
      w_stop_smp  = (r_state == S_STOP)  && (r_cnt == CNT_LAST);
      w_push_req  = w_stop_smp & r_rx_s;
      w_frame_err = w_stop_smp & ~r_rx_s;
   end

   // Baud counter restarts on every state change, so START measures half a bit
   // from the detected edge and every later sample lands one bit period apart.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         r_cnt     <= '0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h00;
      end else begin
         if ((w_state_nxt != r_state) || (r_state == S_IDLE) || (r_cnt == CNT_LAST)) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         if (w_start_smp) begin
            r_bit_idx <= 3'd0;
         end else if (w_data_smp) begin
            r_bit_idx <= r_bit_idx + 3'd1;
            r_shift   <= {r_rx_s, r_shift[7:1]};
         end
      end
   end

   // ---------------------------------------------------------------- events
   logic       r_push;
   logic [7:0] r_push_byte;
   logic       r_frame_err;
   logic       r_overrun;
   logic       w_overrun;

   always_ff @(posedge clk) begin
      if (reset_i) begin
         r_push      <= 1'b0;
         r_push_byte <= 8'h00;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_push      <= w_push_req;
         r_frame_err <= w_frame_err;
         r_overrun   <= w_overrun;
         if (w_push_req) begin
            r_push_byte <= r_shift;
         end
      end
   end

   // ---------------------------------------------------------------- FIFO
   logic [7:0]  r_mem [FIFO_DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic [AW:0] w_wr_nxt;
   logic [AW:0] w_rd_nxt;
   logic [7:0]  r_data;
   logic        w_empty;
   logic        w_full;
   logic        w_pop;
   logic        w_push;

   always_comb begin
      w_empty   = (r_wr_ptr == r_rd_ptr);
      w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
      w_pop     = ~w_empty & ready_i;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      w_push    = r_push & (~w_full | w_pop);
      w_overrun = r_push & w_full & ~w_pop;
      w_wr_nxt  = r_wr_ptr + {{AW{1'b0}}, w_push};
      w_rd_nxt  = r_rd_ptr + {{AW{1'b0}}, w_pop};
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= r_push_byte;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_data   <= 8'h00;
      end else begin
         r_wr_ptr <= w_wr_nxt;
         r_rd_ptr <= w_rd_nxt;
         // Registered head: load the entry that becomes head next cycle. If that
         // entry is the one being written right now, take it from the push path.
         if (w_wr_nxt != w_rd_nxt) begin
            if (w_rd_nxt == r_wr_ptr) begin
               r_data <= r_push_byte;
            end else begin
               r_data <= r_mem[w_rd_nxt[AW-1:0]];
            end
         end
      end
   end

   assign data_o      = r_data;
   assign valid_o     = ~w_empty;
   assign frame_err_o = r_frame_err;
   assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo (CPB = 10, depth 4)

module tb_uart_rx_fifo;

   localparam int CLK_HZ = 1_000_000;
   localparam int BAUD   = 100_000;
   localparam int CPB    = CLK_HZ / BAUD;
   localparam int DEPTH  = 4;
   // Cycles from the first low rx_i cycle to valid_o: 2 sync flops + edge
   // detect, half a bit to the start sample, nine bit periods to the stop
   // sample, one cycle to push.
   localparam int LAT    = 3 + CPB / 2 + 9 * CPB + 1;

   logic       clk = 1'b0;
   logic       reset_i;
   logic       rx_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i;
   logic       frame_err_o;
   logic       overrun_o;

   int checks = 0;
   int errors = 0;
   int n_rx   = 0;
   int n_ferr = 0;
   int n_ovr  = 0;
   int n_both = 0;
   int s_rx, s_ferr, s_ovr;
   int lat;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;

   typedef struct {
      logic [7:0] data;
      logic       stop_bit;
      logic       exp_byte;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[7];

   uart_rx_fifo #(
      .CLK_FREQ_HZ (CLK_HZ),
      .BAUD_RATE   (BAUD),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .reset_i     (reset_i),
      .rx_i        (rx_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard consumer: every accepted byte is compared with the queue head.
   always @(negedge clk) begin
      if (!reset_i) begin
         if (frame_err_o) n_ferr++;
         if (overrun_o) n_ovr++;
         if (frame_err_o && overrun_o) n_both++;
         if (valid_o && ready_i) begin
            n_rx++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rx_byte: got %02h, expected no byte", data_o);
            end else begin
               exp_b = exp_q.pop_front();
               if (data_o !== exp_b) begin
                  errors++;
                  $display("FAIL rx_byte: got %02h, expected %02h", data_o, exp_b);
               end
            end
         end
      end
   end

   task automatic snap();
      s_rx   = n_rx;
      s_ferr = n_ferr;
      s_ovr  = n_ovr;
   endtask

   // Frame starts right after the next rising edge; ends with two idle bit times.
   task automatic send(input logic [7:0] b, input logic stop_bit);
      @(posedge clk);
      #1 rx_i = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rx_i = b[i];
         repeat (CPB) @(posedge clk);
      end
      #1 rx_i = stop_bit;
      repeat (CPB) @(posedge clk);
      #1 rx_i = 1'b1;
      repeat (2 * CPB) @(posedge clk);
   endtask

   task automatic drain_expect(input string name, input int n);
      @(posedge clk);
      #1 ready_i = 1'b1;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check({name, "_valid"}, valid_o, 1);
      end
      @(negedge clk);
      check({name, "_empty"}, valid_o, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish within budget");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{8'h3C, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{8'h01, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{8'h5A, 1'b1, 1'b1, 1'b0};

      rx_i    = 1'b1;
      ready_i = 1'b0;
      reset_i = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_valid", valid_o, 0);
      check("rst_data", data_o, 8'h00);
      check("rst_ferr", frame_err_o, 0);
      check("rst_ovr", overrun_o, 0);
      @(posedge clk);
      #1 reset_i = 1'b0;

      // Test 1: single byte, exact latency
      ready_i = 1'b1;
      exp_q.push_back(8'hA5);
      snap();
      lat = -1;
      fork
         send(8'hA5, 1'b1);
         begin
            @(posedge clk);
            for (int k = 0; k < LAT + 20; k++) begin
               @(negedge clk);
               if (valid_o) begin
                  lat = k;
                  break;
               end
            end
         end
      join
      @(negedge clk);
      check("t1_latency", lat, LAT);
      check("t1_count", n_rx - s_rx, 1);
      check("t1_flags", (n_ferr - s_ferr) + (n_ovr - s_ovr), 0);
      check("t1_empty", valid_o, 0);

      // Test 2: overflow of a 4-deep FIFO
      ready_i = 1'b0;
      snap();
      for (int i = 1; i <= 5; i++) begin
         if (i <= DEPTH) exp_q.push_back(8'(i));
         send(8'(i), 1'b1);
      end
      @(negedge clk);
      check("t2_overrun", n_ovr - s_ovr, 1);
      check("t2_ferr", n_ferr - s_ferr, 0);
      check("t2_head", data_o, 8'h01);
      drain_expect("t2_drain", DEPTH);
      check("t2_queue", exp_q.size(), 0);

      // Table: framing errors and a spread of data patterns
      ready_i = 1'b1;
      for (int v = 0; v < 7; v++) begin
         snap();
         if (vecs[v].exp_byte) exp_q.push_back(vecs[v].data);
         send(vecs[v].data, vecs[v].stop_bit);
         @(negedge clk);
         check($sformatf("vec%0d_rx", v), n_rx - s_rx, 32'(vecs[v].exp_byte));
         check($sformatf("vec%0d_ferr", v), n_ferr - s_ferr, 32'(vecs[v].exp_ferr));
         check($sformatf("vec%0d_ovr", v), n_ovr - s_ovr, 0);
         check($sformatf("vec%0d_empty", v), valid_o, 0);
      end

      // Test 4: short glitch while idle
      snap();
      @(posedge clk);
      #1 rx_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rx_i = 1'b1;
      repeat (3 * CPB) @(posedge clk);
      @(negedge clk);
      check("t4_glitch_rx", n_rx - s_rx, 0);
      check("t4_glitch_flags", (n_ferr - s_ferr) + (n_ovr - s_ovr), 0);
      exp_q.push_back(8'h55);
      send(8'h55, 1'b1);
      @(negedge clk);
      check("t4_after_rx", n_rx - s_rx, 1);

      // Test 5: pop in the same cycle as a push into a full FIFO
      ready_i = 1'b0;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h44);
      exp_q.push_back(8'h66);
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      send(8'h33, 1'b1);
      send(8'h44, 1'b1);
      snap();
      fork
         send(8'h66, 1'b1);
         begin
            @(posedge clk);
            repeat (LAT - 1) @(posedge clk);
            #1 ready_i = 1'b1;
            @(posedge clk);
            #1 ready_i = 1'b0;
         end
      join
      @(negedge clk);
      check("t5_overrun", n_ovr - s_ovr, 0);
      check("t5_popped", n_rx - s_rx, 1);
      check("t5_head", data_o, 8'h22);
      drain_expect("t5_drain", DEPTH);
      check("t5_queue", exp_q.size(), 0);

      // Test 6: reset in the middle of a frame with two bytes queued
      ready_i = 1'b0;
      send(8'h77, 1'b1);
      send(8'h88, 1'b1);
      @(negedge clk);
      check("t6_prefill", valid_o, 1);
      snap();
      fork
         send(8'hF0, 1'b1);
         begin
            @(posedge clk);
            repeat (5 * CPB + 5) @(posedge clk);
            #1 reset_i = 1'b1;
            @(posedge clk);
            #1 reset_i = 1'b0;
            @(negedge clk);
            check("t6_valid_after_rst", valid_o, 0);
            check("t6_data_after_rst", data_o, 8'h00);
         end
      join
      ready_i = 1'b1;
      exp_q.push_back(8'h81);
      send(8'h81, 1'b1);
      @(negedge clk);
      check("t6_rx", n_rx - s_rx, 1);
      check("t6_flags", (n_ferr - s_ferr) + (n_ovr - s_ovr), 0);
      check("t6_empty", valid_o, 0);

      check("final_queue", exp_q.size(), 0);
      check("flags_exclusive", n_both, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
